uart_rx: RTL

- Memory-mapped UART receiver; the receive-side counterpart of the existing uart transmitter on the CPU bus.
- Receives 8N1 frames on the serial input line and buffers them in a first-word-fall-through FIFO.
- Presents the head byte, status and sticky error flags to the MA stage, where loads read them from the UART address.

---
 rtl/uart_rx_if.sv | 34 +++
 rtl/uart_rx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, read handshake and status bundle for uart_rx (parity_err only with UART_RX_PARITY_EN)
`timescale 1ns/1ps
interface uart_rx_if #(
  parameter int CNT_W = 5
);
  logic             uart_rx;
  logic             rd_en;
  logic             err_clr;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [CNT_W-1:0] rx_count;
  logic             frame_err;
  logic             overrun;
  logic             busy;
`ifdef UART_RX_PARITY_EN
  logic             parity_err;
`endif

  modport master (
    output uart_rx, rd_en, err_clr,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    input  rx_data, rx_valid, rx_count, frame_err, overrun, busy
  );

  modport slave (
    input  uart_rx, rd_en, err_clr,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    output rx_data, rx_valid, rx_count, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with first-word-fall-through FIFO and sticky errors
// Optional 8E1 framing with parity_err when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 5
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] HALF_M1 = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] BIT_M1  = TMR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_WAIT_HIGH
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             frame_err_q, overrun_q;
  logic             rxs, push, frame_set;
  logic             empty, full, pop, wr, ovr_set;
`ifdef UART_RX_PARITY_EN
  logic             parity_err_q, parity_set;
`endif

  assign rxs = sync2_q;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q + TMR_W'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_set = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: if (tmr_q == HALF_M1) begin
        tmr_d   = '0;
        idx_d   = '0;
        state_d = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: if (tmr_q == BIT_M1) begin
        tmr_d          = '0;
        shift_d[idx_q] = rxs;
        idx_d          = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (tmr_q == BIT_M1) begin
        tmr_d      = '0;
        parity_set = ^{shift_q, rxs};
        state_d    = S_STOP;
      end
`endif
      S_STOP: if (tmr_q == BIT_M1) begin
        tmr_d = '0;
        if (rxs) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          frame_set = 1'b1;
          state_d   = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        // a held-low line must return high before a new start edge counts
        tmr_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pop is evaluated first so a full FIFO can still accept a byte in a pop cycle.
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = bus.rd_en && !empty;
  assign wr      = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  always_comb begin
    count_d = count_q;
    if (wr && !pop)      count_d = count_q + CNT_W'(1);
    else if (!wr && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= bus.uart_rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      if (wr)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      frame_err_q <= frame_set | (frame_err_q & ~bus.err_clr);
      overrun_q   <= ovr_set | (overrun_q & ~bus.err_clr);
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_set | (parity_err_q & ~bus.err_clr);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= shift_q;
  end

  assign bus.rx_data   = empty ? 8'h00 : mem[rd_ptr_q];
  assign bus.rx_valid  = !empty;
  assign bus.rx_count  = count_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif
endmodule
